fifo_uart_tx: RTL and testbench

Downstream drain stage for the 8-bit synchronous FIFO: pops bytes whenever the FIFO is non-empty and serialises each one onto a UART TX line. Frames are 8 data bits, LSB first, with optional parity and one stop bit. It attaches directly to the FIFO's read side (`rd_en`, `data_out`, `empty`), where read data is registered and valid one cycle after the `rd_en` cycle. The block owns the read pointer advance and never pops an empty FIFO.

---
 rtl/fifo_uart_tx_if.sv | 19 +
 rtl/fifo_uart_tx.sv | 141 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// Read-side link between the 8-bit synchronous FIFO and its UART drain stage.
// fifo_rd_en pops one byte; it is only raised while fifo_empty is low, and fifo_data holds that byte the following cycle.
interface fifo_uart_tx_if;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops bytes whenever available and serialises them as UART frames
// (start, 8 data LSB first, optional parity, one stop bit).
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0
) (
    input  logic           clk,
    input  logic           rst,
    fifo_uart_tx_if.master fifo,
    output logic           tx,
    output logic           busy,
    output logic           tx_done,
    output logic [2:0]     dbg_state_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_PAR   = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          pop;
    logic          done;
    logic          baud_last;

    assign baud_last = (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                pop = !fifo.fifo_empty;
                if (pop) state_d = S_FETCH;
            end
            S_FETCH: begin
                // Parity is latched from the loaded byte, before any shifting.
                shreg_d = fifo.fifo_data;
                par_d   = (^fifo.fifo_data) ^ (PARITY == 2);
                tx_d    = 1'b0;
                baud_d  = '0;
                state_d = S_START;
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    tx_d    = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[7:1]};
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        if (PARITY != 0) begin
                            tx_d    = par_q;
                            state_d = S_PAR;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        tx_d    = shreg_q[0];
                        shreg_d = {1'b0, shreg_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_PAR: begin
                if (baud_last) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                // Final stop cycle doubles as the pop slot for the next byte.
                if (baud_last) begin
                    done    = 1'b1;
                    pop     = !fifo.fifo_empty;
                    baud_d  = '0;
                    state_d = pop ? S_FETCH : S_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign fifo.fifo_rd_en = pop & rst;
    assign tx              = tx_q;
    assign tx_done         = done;
    assign busy            = (state_q != S_IDLE) | fifo.fifo_rd_en;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a frame-level line model checked every cycle, plus directed
// literal checks for reset, single byte, streaming, parity, mid-frame reset and empty guard.
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_uart_tx_if m_if ();
    fifo_uart_tx_if p1_if ();
    fifo_uart_tx_if p2_if ();

    logic       tx, busy, tx_done;
    logic [2:0] dbg_state;
    logic       p1_tx, p1_busy, p1_done, p2_tx, p2_busy, p2_done;
    logic [2:0] p1_state, p2_state;

    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(0)) u_dut (
        .clk(clk), .rst(rst), .fifo(m_if.master),
        .tx(tx), .busy(busy), .tx_done(tx_done), .dbg_state_o(dbg_state)
    );
    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(1)) u_dut_even (
        .clk(clk), .rst(rst), .fifo(p1_if.master),
        .tx(p1_tx), .busy(p1_busy), .tx_done(p1_done), .dbg_state_o(p1_state)
    );
    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(2)) u_dut_odd (
        .clk(clk), .rst(rst), .fifo(p2_if.master),
        .tx(p2_tx), .busy(p2_busy), .tx_done(p2_done), .dbg_state_o(p2_state)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pop_cnt  = 0;
    int done_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // FIFO model feeding the main instance: registered read data, one cycle after the pop.
    logic [7:0] q_fifo[$];
    int         fifo_cnt;
    logic       hold_empty;
    assign m_if.fifo_empty = (fifo_cnt == 0) || hold_empty;

    always @(posedge clk) begin
        if (m_if.fifo_rd_en && !m_if.fifo_empty && q_fifo.size() > 0) begin
            m_if.fifo_data <= q_fifo.pop_front();
            fifo_cnt       <= fifo_cnt - 1;
        end
    end

    task automatic push_byte(input logic [7:0] b);
        q_fifo.push_back(b);
        fifo_cnt++;
    endtask

    // Expected line, one entry per future cycle: {tx_done, tx}.
    logic [1:0] exp_q[$];
    logic       chk_en;

    task automatic push_frame(input logic [7:0] b);
        exp_q.push_back(2'b01);
        repeat (4) exp_q.push_back(2'b00);
        for (int i = 0; i < 8; i++) repeat (4) exp_q.push_back({1'b0, b[i]});
        repeat (3) exp_q.push_back(2'b01);
        exp_q.push_back(2'b11);
    endtask

    logic [1:0] c_e;
    logic       c_had, c_rd;
    always @(negedge clk) begin
        if (chk_en) begin
            c_had = (exp_q.size() > 0);
            c_e   = c_had ? exp_q.pop_front() : 2'b01;
            c_rd  = rst && !m_if.fifo_empty && (!c_had || c_e[1]);
            check("m_tx", tx, c_e[0]);
            check("m_tx_done", tx_done, c_e[1]);
            check("m_rd_en", m_if.fifo_rd_en, c_rd);
            check("m_busy", busy, c_had || c_rd);
            if (tx_done) done_cnt++;
            if (m_if.fifo_rd_en) begin
                pop_cnt++;
                push_frame(q_fifo.size() > 0 ? q_fifo[0] : 8'h00);
            end
            if (!rst) exp_q.delete();
        end
    end

    int   sel;
    logic p_rd, p_tx, p_done;
    assign p_rd   = (sel == 1) ? p1_if.fifo_rd_en : p2_if.fifo_rd_en;
    assign p_tx   = (sel == 1) ? p1_tx : p2_tx;
    assign p_done = (sel == 1) ? p1_done : p2_done;

    task automatic wait_main_pop(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (m_if.fifo_rd_en) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_parity(input int which, input logic [7:0] b, input logic exp_par);
        bit ok;
        int done_at, extra_pops;
        sel = which;
        @(posedge clk); #1;
        if (which == 1) begin p1_if.fifo_data = b; p1_if.fifo_empty = 1'b0; end
        else            begin p2_if.fifo_data = b; p2_if.fifo_empty = 1'b0; end
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (p_rd) begin ok = 1'b1; break; end
        end
        check("t4_pop_seen", ok, 1'b1);
        @(posedge clk); #1;
        if (which == 1) p1_if.fifo_empty = 1'b1;
        else            p2_if.fifo_empty = 1'b1;
        done_at    = 0;
        extra_pops = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (k == 2)  check("t4_start", p_tx, 1'b0);
            if (k == 39) check("t4_parity_bit", p_tx, exp_par);
            if (k == 42) check("t4_stop", p_tx, 1'b1);
            if (p_done && done_at == 0) done_at = k;
            if (p_rd) extra_pops++;
        end
        check("t4_frame_len", done_at - 1, 44);
        check("t4_no_extra_pop", extra_pops, 0);
    endtask

    logic [9:0] pat;
    int         p0, d0;
    int         pop_c[$], done_c[$], start_c[$];
    bit         ok, looking;
    logic       exp_bit;

    initial begin
        rst = 1'b0; hold_empty = 1'b0; fifo_cnt = 0; chk_en = 1'b0; sel = 1;
        m_if.fifo_data  = 8'h00;
        p1_if.fifo_empty = 1'b1; p1_if.fifo_data = 8'h00;
        p2_if.fifo_empty = 1'b1; p2_if.fifo_data = 8'h00;
        push_byte(8'hA5);

        // Reset held low with a non-empty FIFO: the line must stay quiet.
        @(posedge clk); #1 chk_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t1_tx", tx, 1'b1);
            check("t1_rd_en", m_if.fifo_rd_en, 1'b0);
            check("t1_busy", busy, 1'b0);
            check("t1_tx_done", tx_done, 1'b0);
            @(posedge clk); #1;
        end
        rst = 1'b1;

        // Single byte 0xA5.
        p0 = pop_cnt; d0 = done_cnt;
        pat = 10'b1101001010;
        wait_main_pop(8, ok);
        check("t2_pop_seen", ok, 1'b1);
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            exp_bit = (k == 1) ? 1'b1 : pat[(k - 2) / 4];
            check("t2_line", tx, exp_bit);
            if (k == 41) check("t2_done_pulse", tx_done, 1'b1);
        end
        @(negedge clk);
        check("t2_idle_state", dbg_state, 3'd0);
        check("t2_idle_busy", busy, 1'b0);
        check("t2_pops", pop_cnt - p0, 1);
        check("t2_dones", done_cnt - d0, 1);

        // Streaming three bytes.
        @(posedge clk); #1;
        push_byte(8'h00); push_byte(8'hFF); push_byte(8'h3C);
        looking = 1'b0;
        for (int k = 0; k < 140; k++) begin
            @(negedge clk);
            if (m_if.fifo_rd_en) begin pop_c.push_back(cyc); looking = 1'b1; end
            else if (looking && tx == 1'b0) begin start_c.push_back(cyc); looking = 1'b0; end
            if (tx_done) done_c.push_back(cyc);
        end
        check("t3_pops", pop_c.size(), 3);
        check("t3_starts", start_c.size(), 3);
        check("t3_dones", done_c.size(), 3);
        check("t3_start_gap1", (start_c.size() >= 2) ? start_c[1] - start_c[0] : -1, 41);
        check("t3_start_gap2", (start_c.size() >= 3) ? start_c[2] - start_c[1] : -1, 41);
        check("t3_pop2_at_done1", (pop_c.size() >= 2 && done_c.size() >= 1) ? pop_c[1] - done_c[0] : -1, 0);
        check("t3_pop3_at_done2", (pop_c.size() >= 3 && done_c.size() >= 2) ? pop_c[2] - done_c[1] : -1, 0);
        check("t3_first_latency", (start_c.size() >= 1 && pop_c.size() >= 1) ? start_c[0] - pop_c[0] : -1, 2);
        check("t3_idle_busy", busy, 1'b0);

        // Parity modes on the dedicated instances.
        run_parity(1, 8'h07, 1'b1);
        run_parity(2, 8'h07, 1'b0);
        run_parity(1, 8'h03, 1'b0);

        // Reset during data bit 3 of 0x5A, then 0x11 must go out cleanly.
        p0 = pop_cnt; d0 = done_cnt;
        @(posedge clk); #1;
        push_byte(8'h5A); push_byte(8'h11);
        wait_main_pop(8, ok);
        check("t5_pop_seen", ok, 1'b1);
        repeat (19) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("t5_tx_after_reset", tx, 1'b1);
        check("t5_state_after_reset", dbg_state, 3'd0);
        check("t5_repop", m_if.fifo_rd_en, 1'b1);
        wait_idle(60, ok);
        check("t5_idle_reached", ok, 1'b1);
        check("t5_pops", pop_cnt - p0, 2);
        check("t5_dones", done_cnt - d0, 1);

        // Random empty toggling: no pop while empty (model), pops balance completions.
        p0 = pop_cnt; d0 = done_cnt;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) push_byte(8'($urandom_range(0, 255)));
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            hold_empty = 1'($urandom_range(0, 1));
        end
        hold_empty = 1'b1;
        wait_idle(60, ok);
        check("t6_idle_reached", ok, 1'b1);
        check("t6_pops_eq_dones", pop_cnt - p0, done_cnt - d0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
